reg_file_mp: RTL

- Parametrised successor to the 16x32 two-read register file.
- Separate write address, per-byte write enables, per-register dirty tracking, and a sequential clear sweep (FSM) for soft-reset without asserting rst.
- Sits in the datapath between decode (read addresses) and writeback (write port).
- Two asynchronous read ports; one synchronous write port.

---
 rtl/reg_file_mp_if.sv | 40 ++++
 rtl/reg_file_mp.sv | 129 ++++++++++++
 2 files changed

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp_if
// Description : Bundles the read ports, the write port, the clear request
//               and the status outputs of reg_file_mp. The master modport
//               is the decode/writeback side; the slave modport is the
//               register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    localparam int c_NBE   = DATA_W / 8;
    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0]  rd_addr1;
    logic [ADDR_W-1:0]  rd_addr2;
    logic [DATA_W-1:0]  rd_data1;
    logic [DATA_W-1:0]  rd_data2;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [c_NBE-1:0]   wr_be;
    logic [DATA_W-1:0]  wr_data;
    logic               clr_req;
    logic               busy;
    logic               wr_drop;
    logic [c_DEPTH-1:0] dirty;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_be, wr_data, clr_req,
        input  rd_data1, rd_data2, busy, wr_drop, dirty
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_be, wr_data, clr_req,
        output rd_data1, rd_data2, busy, wr_drop, dirty
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : DEPTH x DATA_W register file with two asynchronous read
//               ports, one synchronous byte-enabled write port, per-register
//               dirty bits and a sequential clear sweep (one register per
//               cycle) used as a soft reset.
//               Optional macro REG_FILE_MP_BYPASS_EN enables write-through
//               forwarding of the in-flight write onto the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    reg_file_mp_if.slave     bus
);
    localparam int c_NBE   = DATA_W / 8;
    localparam int c_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(c_DEPTH - 1);

    // Sweep controller states
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SWEEP = 1'b1;

    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_dirty;
    logic [0:0]         r_state;
    logic [ADDR_W-1:0]  r_cnt;
    logic               r_busy;
    logic               r_wr_drop;

    // Storage, dirty tracking and clear-sweep controller in one block so the
    // sweep and the write port can never fight over the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_dirty   <= '0;
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // A write in the same cycle as clr_req lands first; the
                    // sweep clears it later.
                    if (bus.wr_en) begin
                        for (int k = 0; k < c_NBE; k++) begin
                            if (bus.wr_be[k]) begin
                                r_mem[bus.wr_addr][8*k +: 8] <= bus.wr_data[8*k +: 8];
                            end
                        end
                        if (|bus.wr_be) begin
                            r_dirty[bus.wr_addr] <= 1'b1;
                        end
                    end
                    if (bus.clr_req) begin
                        r_state <= c_SWEEP;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                c_SWEEP: begin
                    // clr_req is ignored here; writes are rejected and flagged.
                    r_mem[r_cnt]   <= '0;
                    r_dirty[r_cnt] <= 1'b0;
                    if (bus.wr_en) begin
                        r_wr_drop <= 1'b1;
                    end
                    if (r_cnt == c_LAST) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef REG_FILE_MP_BYPASS_EN
    logic [DATA_W-1:0] w_merged;
    logic              w_fwd;

    // Only forward a write that will actually be stored.
    assign w_fwd = bus.wr_en && (r_state == c_IDLE) && !rst;

    for (genvar k = 0; k < c_NBE; k++) begin : g_merge
        assign w_merged[8*k +: 8] = bus.wr_be[k] ? bus.wr_data[8*k +: 8]
                                                 : r_mem[bus.wr_addr][8*k +: 8];
    end

    // Read ports with write-through forwarding.
    always_comb begin
        bus.rd_data1 = r_mem[bus.rd_addr1];
        bus.rd_data2 = r_mem[bus.rd_addr2];
        if (w_fwd && (bus.rd_addr1 == bus.wr_addr)) begin
            bus.rd_data1 = w_merged;
        end
        if (w_fwd && (bus.rd_addr2 == bus.wr_addr)) begin
            bus.rd_data2 = w_merged;
        end
    end
`else
    // Read ports return stored contents only.
    always_comb begin
        bus.rd_data1 = r_mem[bus.rd_addr1];
        bus.rd_data2 = r_mem[bus.rd_addr2];
    end
`endif

    assign bus.busy    = r_busy;
    assign bus.wr_drop = r_wr_drop;
    assign bus.dirty   = r_dirty;

endmodule
`default_nettype wire
